// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// A multiply uses a radix-2 shift-add loop that builds a 64-bit product. A divide
// uses a radix-2 restoring loop that builds a 32-bit quotient and remainder.
// Signed operations run on operand magnitudes; the result sign is fixed once at
// the end. Every operation takes exactly 32 iterations, so the latency is fixed.
`timescale 1ns/1ps

module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  op_q, op_d;
  // Set when the final result has to be negated.
  logic        neg_q, neg_d;
  // Multiplicand for a multiply, divisor for a divide (magnitude).
  logic [31:0] opnd_q, opnd_d;
  // Multiply: {partial product high, multiplier / product low}.
  // Divide:   {partial remainder, dividend / quotient}.
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  // Iteration datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] iter_acc;

  // Operand capture helpers
  logic        a_signed;
  logic        b_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        sign_cap;

  // Magnitude of a value that is treated as two's complement when is_signed is set.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return ~v + 32'd1;
    end
    return v;
  endfunction

  // Conditional 32-bit two's complement negation.
  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    if (en) begin
      return ~v + 32'd1;
    end
    return v;
  endfunction

  // Conditional 64-bit two's complement negation.
  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    if (en) begin
      return ~v + 64'd1;
    end
    return v;
  endfunction

  // Pick the architectural result from the final accumulator and apply the sign.
  function automatic logic [31:0] finalize(input logic [2:0] fop, input logic fneg,
                                           input logic [63:0] facc);
    logic [63:0] prod_fix;
    prod_fix = neg64(facc, fneg);
    case (fop)
      OP_MUL:                       return prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return prod_fix[63:32];
      OP_DIV, OP_DIVU:              return neg32(facc[31:0], fneg);
      default:                      return neg32(facc[63:32], fneg);
    endcase
  endfunction

  // Decode operand signedness and the result sign from the live inputs (used at capture only).
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    sign_cap = 1'b0;
    case (op)
      OP_MULH: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        sign_cap = A[31] ^ B[31];
      end
      OP_MULHSU: begin
        a_signed = 1'b1;
        sign_cap = A[31];
      end
      OP_DIV: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        // Divide by zero returns all ones for the quotient, so the sign fix is skipped.
        sign_cap = (A[31] ^ B[31]) && (B != 32'd0);
      end
      OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        // The remainder follows the dividend; for B==0 this gives back A.
        sign_cap = A[31];
      end
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        sign_cap = 1'b0;
      end
    endcase
    a_mag = abs32(A, a_signed);
    b_mag = abs32(B, b_signed);
  end

  // One radix-2 step of either shift-add multiply or restoring divide.
  always_comb begin
    // Add the multiplicand when the current multiplier bit is set, then shift right.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    // Shift the next dividend bit into the partial remainder and try to subtract.
    // A compare (not the borrow of a subtract) is used so that a zero divisor
    // always subtracts: this gives an all-ones quotient and the remainder ends as the dividend.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[31:0] - opnd_q;
    if (div_ge) begin
      div_next = {div_diff, acc_q[30:0], 1'b1};
    end else begin
      div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    end
    iter_acc = op_q[2] ? div_next : mul_next;
  end

  // Next-state logic for the controller and datapath registers.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d    = op;
          neg_d   = sign_cap;
          opnd_d  = op[2] ? b_mag : a_mag;
          acc_d   = {32'd0, (op[2] ? a_mag : b_mag)};
          count_d = 5'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = iter_acc;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          result_d = finalize(op_q, neg_q, iter_acc);
          state_d  = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A flush beats both a new request and a completing operation.
    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // Control state and the visible result reset; the working registers do not need to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Working registers: captured operation, sign, divisor/multiplicand and accumulator.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    neg_q  <= neg_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
  end

  assign busy   = (state_q == CALC) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-004 SHALL have port kill, input, 1 bit: pipeline flush, aborts any operation in flight.
REQ-005 SHALL have port op, input, 3 bits: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port A, input, 32 bits: rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port B, input, 32 bits: rs2 operand (multiplier/divisor).
REQ-008 SHALL have port busy, output, 1 bit: high in CALC and DONE; the pipeline stalls on it.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; result is valid.
REQ-010 SHALL have port result, output, 32 bits, registered: last completed result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 IDLE with start=1 and kill=0 at edge E0 SHALL:
- capture op, A and B;
- record result sign; take operand magnitudes where op is signed;
- clear iteration count to 0;
- go to CALC.
REQ-013 CALC SHALL perform exactly one radix-2 iteration per edge:
- multiply: shift-add, 64-bit product;
- divide: restoring, 32-bit quotient and remainder.
REQ-014 The edge with count==31 SHALL do the final iteration, apply sign correction, load result and go to DONE. The fixed latency is 32 edges (E1..E32), with no early termination.
REQ-015 DONE SHALL:
- assert done=1 for exactly one cycle (between E32 and E33);
- return to IDLE at E33, ignoring start on that edge.
REQ-016 result SHALL hold its value from the DONE entry edge until the next DONE entry edge. It is unchanged by start, kill or CALC.
REQ-017 MUL SHALL return product[31:0]. MULH/MULHSU/MULHU SHALL return product[63:32]:
- MULH: signed x signed;
- MULHSU: signed A x unsigned B;
- MULHU: unsigned x unsigned.
REQ-018 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-019 Divide by zero SHALL return:
- DIV/DIVU: quotient 0xFFFFFFFF;
- REM/REMU: remainder equal to A.
REQ-020 Signed overflow (A=0x80000000, B=0xFFFFFFFF) SHALL return DIV 0x80000000 and REM 0x00000000.
REQ-021 In CALC or DONE:
- start SHALL be ignored;
- captured operands SHALL NOT change when inputs A, B or op change.
REQ-022 kill=1 at any edge SHALL force IDLE with done=0 on the next cycle. kill SHALL have priority over start and over CALC completion; result is unchanged.
REQ-023 start and kill high together in IDLE SHALL leave the block in IDLE.
REQ-024 busy SHALL be combinational from state only, with no input-to-output combinational path.

Reset
REQ-025 rst=1 at an edge SHALL force:
- state IDLE;
- busy=0, done=0, result=0x00000000;
- count=0.
REQ-026 rst SHALL have priority over kill and start, including mid-CALC and in DONE. No done pulse SHALL follow a reset-aborted operation.

Verification
REQ-027 MUL, A=7, B=0xFFFFFFFD -> done exactly 32 edges after start edge, result=0xFFFFFFEB; busy high 33 cycles.
REQ-028 MULHU, A=B=0xFFFFFFFF -> result=0xFFFFFFFE; MULH with same operands -> 0x00000000.
REQ-029 DIV, A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM with same operands -> 0xFFFFFFFF. DIV, A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
REQ-030 DIVU, A=5, B=0 -> 0xFFFFFFFF; REMU with same operands -> 0x00000005.
REQ-031 During a DIV, a second start with different A/B at CALC cycle 5 -> ignored; first op result delivered at normal time.
REQ-032 Two abort cases SHALL be covered:
- kill at CALC cycle 10 -> IDLE next cycle, no done, result retains prior value;
- rst at CALC cycle 20 -> result=0, no done; a fresh start after reset completes normally.
